pipe_ctrl: RTL and testbench

Pipeline control unit for the RISC-V core: merges stall and redirect requests from execute, the divider and the bus into the single `hold_flag_o` consumed by PC, fetch and the decode pipeline register. It also sequences interrupt entry: it latches peripheral interrupt requests and waits for a safe point. It then redirects fetch to the trap vector and flushes the front end. It sits beside the decode stage and drives the hold input of every front-end register.

---
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges execute/divider/bus stalls into one hold level
// and sequences interrupt entry (latch, wait for a safe point, redirect, flush).
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int INT_W  = 8,
  localparam int IDX_W = (INT_W > 1) ? $clog2(INT_W) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_ex_i,
  input  logic              hold_bus_i,
  input  logic [INT_W-1:0]  int_req_i,
  input  logic              int_en_i,
  input  logic [ADDR_W-1:0] int_vec_base_i,
  input  logic [ADDR_W-1:0] dec_inst_addr_i,
  output logic [2:0]        hold_flag_o,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [INT_W-1:0]  int_ack_o,
  output logic [IDX_W-1:0]  int_cause_o,
  output logic [ADDR_W-1:0] epc_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_TRAP  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [INT_W-1:0]  pend_q, pend_d;
  logic [IDX_W-1:0]  cause_q, cause_d;
  logic [ADDR_W-1:0] epc_q, epc_d;

  logic [IDX_W-1:0]  sel_idx;
  logic [INT_W-1:0]  ack;
  logic [ADDR_W-1:0] trap_addr;
  logic              in_trap;
  logic              in_flush;
  logic              pass_state;
  logic              quiet;
  logic [1:0]        hold_lvl;

  // Lowest set pending index wins; scanning downward leaves the lowest one.
  always_comb begin
    sel_idx = '0;
    for (int i = INT_W - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    in_trap    = (state_q == ST_TRAP);
    in_flush   = (state_q == ST_FLUSH);
    pass_state = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    quiet      = !hold_ex_i && !hold_bus_i && !jump_flag_i;
    ack        = in_trap ? (INT_W'(1) << cause_q) : '0;
    trap_addr  = int_vec_base_i + (ADDR_W'(cause_q) << 2);
  end

  // Hold level is the maximum of all contributing sources.
  always_comb begin
    hold_lvl = 2'd0;
    if (hold_bus_i) begin
      hold_lvl = 2'd1;
    end
    if (hold_ex_i || jump_flag_i || in_trap || in_flush) begin
      hold_lvl = 2'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    pend_d  = (pend_q | (int_req_i & {INT_W{int_en_i}})) & ~ack;
    unique case (state_q)
      ST_IDLE: begin
        if (jump_flag_i) begin
          state_d = ST_FLUSH;
        end else if (|pend_q) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (jump_flag_i) begin
          state_d = ST_FLUSH;
        end else if (quiet) begin
          state_d = ST_TRAP;
          cause_d = sel_idx;
        end
      end
      ST_TRAP: begin
        state_d = ST_FLUSH;
        epc_d   = dec_inst_addr_i;
      end
      ST_FLUSH: begin
        state_d = (|pend_q) ? ST_WAIT : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // Combinational outputs read as their reset values while reset is asserted.
  always_comb begin
    hold_flag_o = '0;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    int_ack_o   = '0;
    if (rst_n_i) begin
      hold_flag_o = {1'b0, hold_lvl};
      int_ack_o   = ack;
      if (in_trap) begin
        jump_flag_o = 1'b1;
        jump_addr_o = trap_addr;
      end else if (pass_state && jump_flag_i) begin
        jump_flag_o = 1'b1;
        jump_addr_o = jump_addr_i;
      end
    end
  end

  assign int_cause_o = cause_q;
  assign epc_o       = epc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table-driven hold/jump merge plus scripted interrupt
// sequences; trap results are checked against a queue of expected traps.
module tb_pipe_ctrl;

  localparam int ADDR_W = 32;
  localparam int INT_W  = 8;
  localparam int IDX_W  = 3;
  localparam int EXP_W  = INT_W + IDX_W + ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_TRAP  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic              clk;
  logic              rst_n_i;
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_ex_i;
  logic              hold_bus_i;
  logic [INT_W-1:0]  int_req_i;
  logic              int_en_i;
  logic [ADDR_W-1:0] int_vec_base_i;
  logic [ADDR_W-1:0] dec_inst_addr_i;
  logic [2:0]        hold_flag_o;
  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [INT_W-1:0]  int_ack_o;
  logic [IDX_W-1:0]  int_cause_o;
  logic [ADDR_W-1:0] epc_o;

  pipe_ctrl #(.ADDR_W(ADDR_W), .INT_W(INT_W)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .hold_ex_i       (hold_ex_i),
    .hold_bus_i      (hold_bus_i),
    .int_req_i       (int_req_i),
    .int_en_i        (int_en_i),
    .int_vec_base_i  (int_vec_base_i),
    .dec_inst_addr_i (dec_inst_addr_i),
    .hold_flag_o     (hold_flag_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
    .int_ack_o       (int_ack_o),
    .int_cause_o     (int_cause_o),
    .epc_o           (epc_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected trap: one-hot ack, cause index, vector base + 4*index.
  function automatic logic [EXP_W-1:0] trap_exp(input int idx, input logic [ADDR_W-1:0] base);
    logic [INT_W-1:0]  a;
    logic [ADDR_W-1:0] t;
    a = '0;
    a[idx] = 1'b1;
    t = base + ADDR_W'(idx * 4);
    return {a, IDX_W'(idx), t};
  endfunction

  always @(negedge clk) begin
    if (rst_n_i && int_ack_o != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(int_ack_o), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("trap_ack",   64'(int_ack_o),   64'(mon_e[EXP_W-1 -: INT_W]));
        check("trap_cause", 64'(int_cause_o), 64'(mon_e[ADDR_W +: IDX_W]));
        check("trap_addr",  64'(jump_addr_o), 64'(mon_e[ADDR_W-1:0]));
        check("trap_jflag", 64'(jump_flag_o), 64'd1);
        check("trap_hold",  64'(hold_flag_o), 64'd3);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    hold_ex_i   = 1'b0;
    hold_bus_i  = 1'b0;
    int_req_i   = '0;
  endtask

  typedef struct {
    logic              bus;
    logic              ex;
    logic              jmp;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        exp_hold;
    logic              exp_jf;
    logic [ADDR_W-1:0] exp_ja;
  } vec_t;

  vec_t vecs[7];

  initial begin
    rst_n_i         = 1'b0;
    int_en_i        = 1'b0;
    int_vec_base_i  = '0;
    dec_inst_addr_i = '0;
    idle_inputs();

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,        3'd1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        3'd3, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0,        3'd3, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h100,      3'd3, 1'b1, 32'h100};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEC, 3'd3, 1'b1, 32'hDEADBEEC};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 3'd3, 1'b1, 32'hFFFFFFFC};

    // Reset state
    repeat (3) step();
    rst_n_i = 1'b1;
    @(negedge clk);
    check("rst_hold",  64'(hold_flag_o), 64'd0);
    check("rst_jflag", 64'(jump_flag_o), 64'd0);
    check("rst_jaddr", 64'(jump_addr_o), 64'd0);
    check("rst_ack",   64'(int_ack_o),   64'd0);
    check("rst_cause", 64'(int_cause_o), 64'd0);
    check("rst_epc",   64'(epc_o),       64'd0);
    check("rst_state", 64'(dut.state_q), 64'(S_IDLE));
    check("rst_pend",  64'(dut.pend_q),  64'd0);
    step();

    // Table: hold merge and jump pass-through from IDLE
    for (int i = 0; i < 7; i++) begin
      hold_bus_i  = vecs[i].bus;
      hold_ex_i   = vecs[i].ex;
      jump_flag_i = vecs[i].jmp;
      jump_addr_i = vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d_hold", i),  64'(hold_flag_o), 64'(vecs[i].exp_hold));
      check($sformatf("vec%0d_jflag", i), 64'(jump_flag_o), 64'(vecs[i].exp_jf));
      check($sformatf("vec%0d_jaddr", i), 64'(jump_addr_o), 64'(vecs[i].exp_ja));
      step();
      idle_inputs();
      @(negedge clk);
      check($sformatf("vec%0d_after", i), 64'(hold_flag_o), vecs[i].jmp ? 64'd3 : 64'd0);
      step();
      @(negedge clk);
      check($sformatf("vec%0d_settle", i), 64'(hold_flag_o), 64'd0);
      step();
    end

    // Random stall mixes without jumps
    for (int i = 0; i < 8; i++) begin
      hold_bus_i = 1'($urandom_range(0, 1));
      hold_ex_i  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rand_hold", 64'(hold_flag_o), hold_ex_i ? 64'd3 : (hold_bus_i ? 64'd1 : 64'd0));
      step();
    end
    idle_inputs();
    step();

    // Single interrupt on line 3 with a quiet pipeline
    int_en_i        = 1'b1;
    int_vec_base_i  = 32'h2000;
    dec_inst_addr_i = 32'h40;
    int_req_i       = 8'h08;
    exp_q.push_back(trap_exp(3, 32'h2000));
    step();
    int_req_i = '0;
    @(negedge clk);
    check("i1_pend",  64'(dut.pend_q), 64'h08);
    check("i1_idle",  64'(dut.state_q), 64'(S_IDLE));
    step();
    @(negedge clk);
    check("i1_wait",  64'(dut.state_q), 64'(S_WAIT));
    check("i1_whold", 64'(hold_flag_o), 64'd0);
    step();
    @(negedge clk);
    check("i1_trap",  64'(dut.state_q), 64'(S_TRAP));
    check("i1_epc_pre", 64'(epc_o), 64'd0);
    step();
    @(negedge clk);
    check("i1_epc",   64'(epc_o), 64'h40);
    check("i1_flush", 64'(hold_flag_o), 64'd3);
    check("i1_noack", 64'(int_ack_o), 64'd0);
    step();
    @(negedge clk);
    check("i1_done",  64'(hold_flag_o), 64'd0);
    check("i1_pend0", 64'(dut.pend_q), 64'd0);
    step();

    // Two lines pending while the divider is busy
    hold_ex_i       = 1'b1;
    int_req_i       = 8'h06;
    dec_inst_addr_i = 32'h80;
    exp_q.push_back(trap_exp(1, 32'h2000));
    exp_q.push_back(trap_exp(2, 32'h2000));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_noack", 64'(int_ack_o), 64'd0);
      check("busy_hold",  64'(hold_flag_o), 64'd3);
      step();
      int_req_i = '0;
    end
    hold_ex_i = 1'b0;
    @(negedge clk);
    check("busy_wait", 64'(dut.state_q), 64'(S_WAIT));
    step();
    @(negedge clk);
    check("b1_ack", 64'(int_ack_o), 64'h02);
    step();
    dec_inst_addr_i = 32'h84;
    @(negedge clk);
    check("b1_flush", 64'(dut.state_q), 64'(S_FLUSH));
    check("b1_epc",   64'(epc_o), 64'h80);
    step();
    @(negedge clk);
    check("b2_wait", 64'(dut.state_q), 64'(S_WAIT));
    step();
    @(negedge clk);
    check("b2_ack", 64'(int_ack_o), 64'h04);
    step();
    step();
    @(negedge clk);
    check("b2_epc",  64'(epc_o), 64'h84);
    check("b2_idle", 64'(dut.state_q), 64'(S_IDLE));
    step();

    // Requests while disabled are not latched; then all eight, lowest first
    int_en_i  = 1'b0;
    int_req_i = 8'hFF;
    dec_inst_addr_i = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check("dis_pend", 64'(dut.pend_q), 64'd0);
      check("dis_ack",  64'(int_ack_o), 64'd0);
    end
    step();
    int_en_i = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(trap_exp(i, 32'h2000));
    step();
    int_req_i = '0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("all8_drained", 64'(exp_q.size()), 64'd0);
    step();
    @(negedge clk);
    check("all8_idle", 64'(dut.state_q), 64'(S_IDLE));
    check("all8_pend", 64'(dut.pend_q), 64'd0);
    step();

    // Jump and eligible interrupt in the same cycle: jump wins
    int_req_i       = 8'h20;
    dec_inst_addr_i = 32'h1F0;
    exp_q.push_back(trap_exp(5, 32'h2000));
    step();
    int_req_i = '0;
    step();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h300;
    @(negedge clk);
    check("jw_state", 64'(dut.state_q), 64'(S_WAIT));
    check("jw_jflag", 64'(jump_flag_o), 64'd1);
    check("jw_jaddr", 64'(jump_addr_o), 64'h300);
    check("jw_noack", 64'(int_ack_o), 64'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("jw_flush", 64'(dut.state_q), 64'(S_FLUSH));
    check("jw_pend",  64'(dut.pend_q), 64'h20);
    step();
    @(negedge clk);
    check("jw_wait", 64'(dut.state_q), 64'(S_WAIT));
    step();
    step();
    step();
    @(negedge clk);
    check("jw_idle", 64'(dut.state_q), 64'(S_IDLE));
    check("jw_epc",  64'(epc_o), 64'h1F0);
    step();

    // Reset asserted during TRAP drops the interrupt
    int_req_i = 8'h10;
    step();
    int_req_i = '0;
    step();
    step();
    rst_n_i   = 1'b0;
    int_req_i = 8'h02;
    @(negedge clk);
    check("rt_in_trap", 64'(dut.state_q), 64'(S_TRAP));
    step();
    rst_n_i   = 1'b1;
    int_req_i = '0;
    @(negedge clk);
    check("rt_state", 64'(dut.state_q), 64'(S_IDLE));
    check("rt_pend",  64'(dut.pend_q), 64'd0);
    check("rt_hold",  64'(hold_flag_o), 64'd0);
    check("rt_jflag", 64'(jump_flag_o), 64'd0);
    check("rt_jaddr", 64'(jump_addr_o), 64'd0);
    check("rt_ack",   64'(int_ack_o), 64'd0);
    check("rt_cause", 64'(int_cause_o), 64'd0);
    check("rt_epc",   64'(epc_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      check("rt_quiet_ack", 64'(int_ack_o), 64'd0);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
